// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op encodings, RV32I opcodes and decoded-entry type shared by decoder and ALU
package alu_pkg;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'b000000,
    ALU_SLL  = 6'b000001,
    ALU_SLT  = 6'b000010,
    ALU_SLTU = 6'b000011,
    ALU_XOR  = 6'b000100,
    ALU_SRL  = 6'b000101,
    ALU_SRA  = 6'b000110,
    ALU_OR   = 6'b000111,
    ALU_AND  = 6'b001000,
    ALU_JALR = 6'b001001,
    ALU_SUB  = 6'b001010
  } alu_op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } dec_entry_t;

  // Base-encoding funct3 mapping; shift-right variant is resolved by the caller.
  function automatic alu_op_e funct3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// rtl/alu_op_decode_comb.sv - combinational RV32I to ALU-entry decode
module alu_op_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output dec_entry_t  o_entry
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;
  alu_op_e     w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_bad;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_shamt  = {27'b0, i_instr[24:20]};

  always_comb begin
    w_op  = ALU_ADD;
    w_a   = '0;
    w_b   = '0;
    w_bad = 1'b0;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_a  = i_rs1;
        w_b  = w_imm_i;
        w_op = funct3_op(w_funct3);
        if (w_funct3 == 3'b001) begin
          w_b   = w_shamt;
          w_bad = (w_funct7 != F7_BASE);
        end else if (w_funct3 == 3'b101) begin
          w_b = w_shamt;
          if (w_funct7 == F7_ALT)       w_op  = ALU_SRA;
          else if (w_funct7 != F7_BASE) w_bad = 1'b1;
        end
      end
      OPC_OP: begin
        w_a = i_rs1;
        w_b = i_rs2;
        if (w_funct7 == F7_BASE)                           w_op  = funct3_op(w_funct3);
        else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) w_op  = ALU_SUB;
        else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) w_op  = ALU_SRA;
        else                                               w_bad = 1'b1;
      end
      OPC_LUI: begin
        w_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_a = i_pc;
        w_b = w_imm_u;
      end
      OPC_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_op = ALU_JALR;
          w_a  = i_rs1;
          w_b  = w_imm_i;
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase
    // Illegal encodings present a neutral ADD 0,0 so the ALU never sees garbage.
    if (w_bad) begin
      w_op = ALU_ADD;
      w_a  = '0;
      w_b  = '0;
    end
  end

  assign o_entry = '{
    op:      w_op,
    a:       w_a,
    b:       w_b,
    rd:      i_instr[11:7],
    we:      !w_bad && (i_instr[11:7] != 5'd0),
    illegal: w_bad
  };

endmodule

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - RV32I ALU op decoder with 2-entry registered skid buffer
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        dec_rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [5:0]  ALUop_o,
  output logic [31:0] operand_A_o,
  output logic [31:0] operand_B_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e     r_state;
  logic       r_in_ready;
  logic       r_out_valid;
  dec_entry_t r_head;
  dec_entry_t r_skid;
  dec_entry_t w_dec;
  logic       w_accept;
  logic       w_drain;

  alu_op_decode_comb u_decode (
    .i_instr (instr_i),
    .i_pc    (pc_i),
    .i_rs1   (rs1_data_i),
    .i_rs2   (rs2_data_i),
    .o_entry (w_dec)
  );

  assign w_accept = in_valid_i && r_in_ready;
  assign w_drain  = r_out_valid && out_ready_i;

  // r_head drives the outputs; r_skid catches the one beat accepted while the head stalls.
  always_ff @(posedge clk_i or negedge dec_rst_i) begin
    if (!dec_rst_i) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
    end else if (flush_i) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_head      <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({w_accept, w_drain})
            2'b10: begin
              r_skid     <= w_dec;
              r_in_ready <= 1'b0;
              r_state    <= ST_TWO;
            end
            2'b01: begin
              r_out_valid <= 1'b0;
              r_state     <= ST_EMPTY;
            end
            2'b11:   r_head <= w_dec;
            default: ;
          endcase
        end
        ST_TWO: begin
          if (w_drain) begin
            r_head     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign ALUop_o     = r_head.op;
  assign operand_A_o = r_head.a;
  assign operand_B_o = r_head.b;
  assign rd_o        = r_head.rd;
  assign rd_we_o     = r_head.we;
  assign illegal_o   = r_head.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - scoreboard bench for alu_op_decoder against a mnemonic-level reference model
module tb_alu_op_decoder;

  logic        clk_i = 1'b0;
  logic        dec_rst_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [5:0]  ALUop_o;
  logic [31:0] operand_A_o;
  logic [31:0] operand_B_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic        illegal_o;

  alu_op_decoder dut (
    .clk_i       (clk_i),
    .dec_rst_i   (dec_rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .ALUop_o     (ALUop_o),
    .operand_A_o (operand_A_o),
    .operand_B_o (operand_B_o),
    .rd_o        (rd_o),
    .rd_we_o     (rd_we_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;
  bit   chk_lat = 0;
  int   n_lat_deliv = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic string f3_name(input logic [2:0] f3);
    case (f3)
      3'd0: return "ADD";
      3'd1: return "SLL";
      3'd2: return "SLT";
      3'd3: return "SLTU";
      3'd4: return "XOR";
      3'd5: return "SRL";
      3'd6: return "OR";
      default: return "AND";
    endcase
  endfunction

  function automatic logic [5:0] op_code(input string nm);
    case (nm)
      "SLL":  return 6'd1;
      "SLT":  return 6'd2;
      "SLTU": return 6'd3;
      "XOR":  return 6'd4;
      "SRL":  return 6'd5;
      "SRA":  return 6'd6;
      "OR":   return 6'd7;
      "AND":  return 6'd8;
      "JALR": return 6'd9;
      "SUB":  return 6'd10;
      default: return 6'd0;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    string       nm;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [6:0]  f7;
    logic [2:0]  f3;
    imm_i = 32'($signed(ins[31:20]));
    imm_u = ins & 32'hFFFF_F000;
    f7    = ins[31:25];
    f3    = ins[14:12];
    nm    = "ILL";
    e.a   = 0;
    e.b   = 0;
    case (ins[6:0])
      7'h13: begin
        e.a = r1;
        e.b = imm_i;
        nm  = f3_name(f3);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = 32'(ins[24:20]);
          if (f3 == 3'd5 && f7 == 7'h20) nm = "SRA";
          else if (f7 != 7'h00)          nm = "ILL";
        end
      end
      7'h33: begin
        e.a = r1;
        e.b = r2;
        if (f7 == 7'h00)                   nm = f3_name(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) nm = "SUB";
        else if (f7 == 7'h20 && f3 == 3'd5) nm = "SRA";
      end
      7'h37: begin nm = "ADD"; e.b = imm_u; end
      7'h17: begin nm = "ADD"; e.a = pc; e.b = imm_u; end
      7'h67: if (f3 == 3'd0) begin nm = "JALR"; e.a = r1; e.b = imm_i; end
      default: ;
    endcase
    e.rd  = ins[11:7];
    e.ill = (nm == "ILL");
    e.op  = op_code(nm);
    e.we  = !e.ill && (e.rd != 0);
    if (e.ill) begin
      e.a = 0;
      e.b = 0;
    end
    e.cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: x[6:0] = 7'h13;
      3, 4:    x[6:0] = 7'h33;
      5:       x[6:0] = 7'h37;
      6:       x[6:0] = 7'h17;
      7: begin
        x[6:0] = 7'h67;
        if ($urandom_range(0, 3) != 0) x[14:12] = 3'd0;
      end
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0, 1: x[31:25] = 7'h00;
      2:    x[31:25] = 7'h20;
      default: ;
    endcase
    return x;
  endfunction

  task automatic scoreboard_loop();
    exp_t e;
    exp_t held;
    bit   stalled = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!dec_rst_i || flush_i) begin
        q.delete();
        stalled = 0;
      end else begin
        if (stalled && out_valid_o) begin
          check("stall_op", 32'(ALUop_o), 32'(held.op));
          check("stall_a", operand_A_o, held.a);
          check("stall_b", operand_B_o, held.b);
          check("stall_rd", 32'(rd_o), 32'(held.rd));
        end
        stalled = out_valid_o && !out_ready_i;
        if (stalled) begin
          held.op = ALUop_o;
          held.a  = operand_A_o;
          held.b  = operand_B_o;
          held.rd = rd_o;
        end
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) begin
            check("unexpected_output", 32'(out_valid_o), 32'd0);
          end else begin
            e = q.pop_front();
            check("op", 32'(ALUop_o), 32'(e.op));
            check("operand_a", operand_A_o, e.a);
            check("operand_b", operand_B_o, e.b);
            check("rd", 32'(rd_o), 32'(e.rd));
            check("rd_we", 32'(rd_we_o), 32'(e.we));
            check("illegal", 32'(illegal_o), 32'(e.ill));
            if (chk_lat) begin
              check("latency", cyc, e.cyc + 1);
              n_lat_deliv++;
            end
          end
        end
        if (in_valid_i && in_ready_o) begin
          e     = ref_decode(instr_i, pc_i, rs1_data_i, rs2_data_i);
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    bit acc;
    int n;
    n          = 0;
    in_valid_i = 1'b1;
    instr_i    = ins;
    pc_i       = pc;
    rs1_data_i = r1;
    rs2_data_i = r2;
    do begin
      @(negedge clk_i);
      acc = in_ready_o;
      step();
      n++;
    end while (!acc && n < 40);
    if (!acc) check("send_accept_timeout", 32'(acc), 32'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready_o), 32'd0);
    check({tag, "_aluop"}, 32'(ALUop_o), 32'd0);
    check({tag, "_a"}, operand_A_o, 32'd0);
    check({tag, "_b"}, operand_B_o, 32'd0);
    check({tag, "_rd"}, 32'(rd_o), 32'd0);
    check({tag, "_rd_we"}, 32'(rd_we_o), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_o), 32'd0);
  endtask

  task automatic addi_directed(input string tag);
    out_ready_i = 1'b1;
    send(32'hFFF1_0093, 32'h100, 32'd5, 32'd0);
    check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, "_op"}, 32'(ALUop_o), 32'h00);
    check({tag, "_a"}, operand_A_o, 32'd5);
    check({tag, "_b"}, operand_B_o, 32'hFFFF_FFFF);
    check({tag, "_rd"}, 32'(rd_o), 32'd1);
    check({tag, "_rd_we"}, 32'(rd_we_o), 32'd1);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    fork
      scoreboard_loop();
    join_none

    #2;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk_i);
    #1;
    dec_rst_i = 1'b1;
    check("ready_before_edge", 32'(in_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("ready_after_release", 32'(in_ready_o), 32'd1);

    addi_directed("addi");

    send(32'h4042_5193, 32'h0, 32'h8000_0000, 32'h0);
    check("srai_op", 32'(ALUop_o), 32'h06);
    check("srai_b", operand_B_o, 32'd4);
    check("srai_illegal", 32'(illegal_o), 32'd0);
    send(32'hFE42_5193, 32'h0, 32'h8000_0000, 32'h0);
    check("srai_f7x_illegal", 32'(illegal_o), 32'd1);
    check("srai_f7x_rd_we", 32'(rd_we_o), 32'd0);
    idle(2);

    out_ready_i = 1'b0;
    send(32'h0020_81B3, 32'h0, 32'd7, 32'd9);
    send(32'h4020_8233, 32'h0, 32'd7, 32'd9);
    in_valid_i = 1'b1;
    instr_i    = 32'h0020_F2B3;
    repeat (3) begin
      @(negedge clk_i);
      check("two_held_ready", 32'(in_ready_o), 32'd0);
      check("two_held_valid", 32'(out_valid_o), 32'd1);
      @(posedge clk_i);
      #1;
    end
    out_ready_i = 1'b1;
    send(32'h0020_F2B3, 32'h0, 32'd7, 32'd9);
    idle(4);

    chk_lat     = 1;
    n_lat_deliv = 0;
    for (int i = 0; i < 8; i++) send(rand_instr(), $urandom, $urandom, $urandom);
    idle(3);
    chk_lat = 0;
    check("b2b_deliveries", n_lat_deliv, 8);

    out_ready_i = 1'b0;
    send(32'h0010_0093, 32'h0, 32'd1, 32'd0);
    send(32'h0020_0113, 32'h0, 32'd1, 32'd0);
    in_valid_i = 1'b1;
    instr_i    = 32'h0030_0193;
    flush_i    = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_valid", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b1;
    idle(4);
    check("flush_valid_later", 32'(out_valid_o), 32'd0);
    check("flush_ready", 32'(in_ready_o), 32'd1);

    out_ready_i = 1'b0;
    send(32'h0050_0293, 32'h0, 32'd3, 32'd0);
    send(32'h0060_0313, 32'h0, 32'd3, 32'd0);
    #2;
    dec_rst_i = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    dec_rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_ready_after", 32'(in_ready_o), 32'd1);
    addi_directed("post_rst_addi");

    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      send(rand_instr(), $urandom, $urandom, $urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy    = 0;
    out_ready_i = 1'b1;
    w = 0;
    while (q.size() != 0 && w < 20) begin
      idle(1);
      w++;
    end
    check("drain_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 SHALL have: clk_i  in  1  clock; all state on rising edge.
REQ-002 SHALL have: dec_rst_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: in_valid_i  in  1 / in_ready_o  out  1  upstream handshake; transfer when both high.
REQ-004 SHALL have: instr_i  in  32  RV32I instruction; pc_i  in  32  its PC.
REQ-005 SHALL have: rs1_data_i, rs2_data_i  in  32 each  register-file read data, valid with in_valid_i.
REQ-006 SHALL have: flush_i  in  1  discard all held entries.
REQ-007 SHALL have: out_valid_o  out  1 / out_ready_i  in  1  downstream handshake toward the ALU.
REQ-008 SHALL have: ALUop_o  out  6, operand_A_o  out  32, operand_B_o  out  32, rd_o  out  5, rd_we_o  out  1, illegal_o  out  1.

Function
REQ-009 SHALL encode ALUop: ADD 000000, SLL 000001, SLT 000010, SLTU 000011, XOR 000100, SRL 000101, SRA 000110, OR 000111, AND 001000, JALR 001001, SUB 001010.
REQ-010 SHALL decode OP-IMM (0010011): funct3 selects op, A=rs1_data_i, B=sign-extended imm[11:0].
REQ-011 SHALL decode SLLI/SRLI/SRAI: B={27'b0,instr[24:20]}; funct7 0000000 (SLL/SRL) or 0100000 (SRAI only); other funct7 or SLLI with 0100000 -> illegal.
REQ-012 SHALL decode OP (0110011): A=rs1, B=rs2; funct7 0100000 valid only for SUB/SRA; other funct7 values except 0000000 -> illegal.
REQ-013 SHALL decode LUI: ADD, A=0, B={instr[31:12],12'b0}; AUIPC: ADD, A=pc_i, B=same U-imm.
REQ-014 SHALL decode JALR (1100111, funct3 000): JALR op, A=rs1, B=sign-extended I-imm.
REQ-015 SHALL treat every other opcode as illegal: illegal_o=1, ALUop=ADD, A=B=0, rd_we_o=0.
REQ-016 SHALL drive rd_o=instr[11:7], rd_we_o=1 for legal decodes with rd!=0, else 0.
REQ-017 SHALL register outputs: accepted instruction appears on out_valid_o exactly 1 cycle after acceptance.
REQ-018 SHALL use 2-entry skid buffer, FSM EMPTY/ONE/TWO: EMPTY+accept->ONE; ONE+accept+!drain->TWO; ONE+drain+!accept->EMPTY; TWO+drain->ONE; accept+drain in ONE stays ONE.
REQ-019 SHALL drive in_ready_o registered: high in EMPTY/ONE, low in TWO.
REQ-020 SHALL keep output payload stable while out_valid_o=1 and out_ready_i=0.
REQ-021 SHALL on flush_i: go to EMPTY next cycle, drop held entries and any same-cycle input, out_valid_o=0 next cycle; flush dominates accept/drain.
REQ-022 SHALL sustain one instruction per cycle when out_ready_i stays high.

Reset
REQ-023 SHALL on dec_rst_i low, immediately: state EMPTY, out_valid_o=0, in_ready_o=0, ALUop_o=0, operands 0, rd_o=0, rd_we_o=0, illegal_o=0.
REQ-024 SHALL raise in_ready_o the first clock edge after reset release; reset mid-transfer discards all entries.

Structure
REQ-025 SHALL place ALUop encodings, opcode constants and a decoded-entry struct (op, A, B, rd, we, illegal) in shared package alu_pkg, also used by the ALU.
REQ-026 SHALL split combinational decode into sub-module alu_op_decode_comb; skid/FSM stays in top.

Verification
REQ-027 ADDI x1,x2,-1 (0xFFF10093), rs1=5, ready high -> next cycle ALUop 000000, A=5, B=0xFFFFFFFF, rd=1, rd_we=1.
REQ-028 SRAI x3,x4,4 (0x40425193), rs1=0x80000000 -> ALUop 000110, B=4, illegal=0; funct7 0x7F variant -> illegal=1, rd_we=0.
REQ-029 out_ready_i low 3 cycles, in_valid_i high -> two entries held, in_ready_o low, payload stable, both delivered in order after release.
REQ-030 Back-to-back 8 instructions with out_ready_i high -> 8 outputs in 8 consecutive cycles, one-cycle latency.
REQ-031 flush_i asserted in state TWO with in_valid_i high -> out_valid_o 0 next cycle, no entries emitted.
REQ-032 dec_rst_i low mid-stream -> outputs zero without clock edge; after release, first new instruction decoded correctly.
